// File: rtl/viterbi_pkg.sv
// Shared definitions for the 64-state, rate-1/2 Viterbi decoder datapath.
//   NSTATES     : number of trellis states
//   STATE_W     : bits needed to index a state
//   BM_W        : width of one branch metric code (0..2, code 3 unused)
//   PM_INIT_DEF : default starting metric for every state other than state 0
package viterbi_pkg;

  localparam int NSTATES     = 64;
  localparam int STATE_W     = 6;
  localparam int BM_W        = 2;
  localparam int PM_INIT_DEF = 64;

endpackage : viterbi_pkg

// File: rtl/acs_cell.sv
// Single add-compare-select cell for one destination state.
// Ports:
//   pm_lo, bm_lo : metric and branch metric of the predecessor with MSB 0
//   pm_hi, bm_hi : metric and branch metric of the predecessor with MSB 1
//   pm_new       : surviving candidate metric (PM_W-bit wrapping add)
//   dec          : 1 when the MSB-1 predecessor wins; a tie keeps MSB-0
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_lo,
  input  logic [BM_W-1:0] bm_lo,
  input  logic [PM_W-1:0] pm_hi,
  input  logic [BM_W-1:0] bm_hi,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] cand_lo;
  logic [PM_W-1:0] cand_hi;

  assign cand_lo = pm_lo + PM_W'(bm_lo);
  assign cand_hi = pm_hi + PM_W'(bm_hi);
  assign dec     = (cand_hi < cand_lo);
  assign pm_new  = dec ? cand_hi : cand_lo;

endmodule : acs_cell

// File: rtl/acs_pm_unit_64.sv
// Add-compare-select and path-metric unit for the 64-state Viterbi decoder.
// Stage 1 runs 64 ACS cells on the registered metrics (or the frame-start
// vector), normalizes, and registers metrics plus survivor decisions.
// Stage 2 registers the index and value of the smallest stored metric.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   in_valid          : one trellis step of branch metrics this cycle
//   in_first          : with in_valid, restart the trellis from state 0
//   bm0, bm1          : per-state branch metrics for input bit 0 / 1
//   dec_valid, dec    : survivor decisions, one bit per state
//   pm_out            : registered path metrics, state n at [n*PM_W +: PM_W]
//   best_valid        : best_state/best_metric valid, one cycle after dec
//   best_state        : lowest index holding the minimum metric
//   best_metric       : that minimum metric
module acs_pm_unit_64
  import viterbi_pkg::*;
#(
  parameter int PM_W    = 8,
  parameter int PM_INIT = PM_INIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [BM_W*NSTATES-1:0] bm0,
  input  logic [BM_W*NSTATES-1:0] bm1,
  output logic                    dec_valid,
  output logic [NSTATES-1:0]      dec,
  output logic [NSTATES*PM_W-1:0] pm_out,
  output logic                    best_valid,
  output logic [STATE_W-1:0]      best_state,
  output logic [PM_W-1:0]         best_metric
);

  localparam logic [PM_W-1:0] INIT_PM = PM_W'(PM_INIT);

  // Metric spread is bounded well below 2^(PM_W-1), so once every metric has
  // its MSB set, clearing it subtracts the same offset from all of them.
  function automatic logic [PM_W-1:0] norm_pm(input logic [PM_W-1:0] v,
                                              input logic             all_hi);
    norm_pm = all_hi ? {1'b0, v[PM_W-2:0]} : v;
  endfunction

  logic [PM_W-1:0]    base_p0 [NSTATES];
  logic [PM_W-1:0]    cand_p0 [NSTATES];
  logic [NSTATES-1:0] dsel_p0;
  logic [NSTATES-1:0] msb_p0;
  logic               all_hi_p0;

  logic [PM_W-1:0]    pm_p1 [NSTATES];
  logic [NSTATES-1:0] dec_p1;
  logic               vld_p1;
  logic [STATE_W-1:0] min_idx_p1;
  logic [PM_W-1:0]    min_val_p1;

  logic               vld_p2;
  logic [STATE_W-1:0] best_state_p2;
  logic [PM_W-1:0]    best_metric_p2;

  // ---- stage 0: base metrics, ACS array, normalization detect ----
  always_comb begin
    for (int i = 0; i < NSTATES; i++) begin
      if (in_first) begin
        base_p0[i] = (i == 0) ? '0 : INIT_PM;
      end else begin
        base_p0[i] = pm_p1[i];
      end
    end
  end

  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam int P_LO = n / 2;
    localparam int P_HI = n / 2 + NSTATES / 2;
    localparam bit U    = (n % 2) == 1;

    logic [BM_W-1:0] bm_lo;
    logic [BM_W-1:0] bm_hi;

    assign bm_lo = U ? bm1[BM_W*P_LO +: BM_W] : bm0[BM_W*P_LO +: BM_W];
    assign bm_hi = U ? bm1[BM_W*P_HI +: BM_W] : bm0[BM_W*P_HI +: BM_W];

    acs_cell #(
      .PM_W (PM_W)
    ) u_acs (
      .pm_lo  (base_p0[P_LO]),
      .bm_lo  (bm_lo),
      .pm_hi  (base_p0[P_HI]),
      .bm_hi  (bm_hi),
      .pm_new (cand_p0[n]),
      .dec    (dsel_p0[n])
    );

    assign msb_p0[n] = cand_p0[n][PM_W-1];
    assign pm_out[n*PM_W +: PM_W] = pm_p1[n];
  end

  assign all_hi_p0 = &msb_p0;

  // ---- stage 1: path metric and decision registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_p1[i] <= (i == 0) ? '0 : INIT_PM;
      end
      dec_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NSTATES; i++) begin
          pm_p1[i] <= norm_pm(cand_p0[i], all_hi_p0);
        end
        dec_p1 <= dsel_p0;
      end
    end
  end

  // Pairwise reduction; the left (lower-index) operand wins ties at every
  // level, which yields the lowest index among equal minima.
  always_comb begin : min_tree
    logic [PM_W-1:0]    tv [NSTATES];
    logic [STATE_W-1:0] ti [NSTATES];
    for (int i = 0; i < NSTATES; i++) begin
      tv[i] = pm_p1[i];
      ti[i] = STATE_W'(i);
    end
    for (int lv = 1; lv <= STATE_W; lv++) begin
      for (int i = 0; i < (NSTATES >> lv); i++) begin
        if (tv[2*i+1] < tv[2*i]) begin
          tv[i] = tv[2*i+1];
          ti[i] = ti[2*i+1];
        end else begin
          tv[i] = tv[2*i];
          ti[i] = ti[2*i];
        end
      end
    end
    min_val_p1 = tv[0];
    min_idx_p1 = ti[0];
  end

  // ---- stage 2: best-state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2         <= 1'b0;
      best_state_p2  <= '0;
      best_metric_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        best_state_p2  <= min_idx_p1;
        best_metric_p2 <= min_val_p1;
      end
    end
  end

  assign dec_valid   = vld_p1;
  assign dec         = dec_p1;
  assign best_valid  = vld_p2;
  assign best_state  = best_state_p2;
  assign best_metric = best_metric_p2;

endmodule : acs_pm_unit_64

// File: tb/tb_acs_pm_unit_64.sv
// Self-checking bench for acs_pm_unit_64: a reference trellis model pushes
// expected decisions/metrics and best-state results into queues; a negedge
// monitor pops and compares them, and each scenario task adds inline checks.
module tb_acs_pm_unit_64;

  localparam int PMW  = 8;
  localparam int MOD  = 256;
  localparam int HALF = 128;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_first;
  logic [127:0] bm0;
  logic [127:0] bm1;
  logic         dec_valid;
  logic [63:0]  dec;
  logic [511:0] pm_out;
  logic         best_valid;
  logic [5:0]   best_state;
  logic [7:0]   best_metric;

  acs_pm_unit_64 #(
    .PM_W    (PMW),
    .PM_INIT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .bm0         (bm0),
    .bm1         (bm1),
    .dec_valid   (dec_valid),
    .dec         (dec),
    .pm_out      (pm_out),
    .best_valid  (best_valid),
    .best_state  (best_state),
    .best_metric (best_metric)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  dec;
    logic [511:0] pm;
  } dec_exp_t;

  typedef struct {
    logic [5:0] st;
    logic [7:0] met;
  } best_exp_t;

  dec_exp_t  dq [$];
  best_exp_t bq [$];
  dec_exp_t  mon_de;
  best_exp_t mon_be;

  int mpm [64];
  int checks;
  int errors;
  int dec_cnt;
  int best_cnt;

  logic [127:0] B0;
  logic [127:0] B1;
  logic [127:0] B2;

  function automatic logic [511:0] init_vec();
    logic [511:0] v;
    for (int s = 0; s < 64; s++) v[s*8 +: 8] = (s == 0) ? 8'd0 : 8'd64;
    return v;
  endfunction

  function automatic logic [127:0] rand_bm();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) mpm[s] = (s == 0) ? 0 : 64;
  endtask

  // Reference trellis step: walks destination states, picks the cheaper
  // predecessor, then normalizes if every new metric reached HALF.
  task automatic model_step(input logic f, input logic [127:0] b0,
                            input logic [127:0] b1);
    int        base [64];
    int        nw   [64];
    logic [63:0] d;
    bit        all_hi;
    dec_exp_t  de;
    best_exp_t be;
    int        bi;
    for (int s = 0; s < 64; s++) base[s] = f ? ((s == 0) ? 0 : 64) : mpm[s];
    all_hi = 1'b1;
    for (int n = 0; n < 64; n++) begin
      int pa, pb, ca, cb;
      pa = n / 2;
      pb = pa + 32;
      if (n % 2 == 1) begin
        ca = (base[pa] + int'(b1[2*pa +: 2])) % MOD;
        cb = (base[pb] + int'(b1[2*pb +: 2])) % MOD;
      end else begin
        ca = (base[pa] + int'(b0[2*pa +: 2])) % MOD;
        cb = (base[pb] + int'(b0[2*pb +: 2])) % MOD;
      end
      d[n]  = (cb < ca);
      nw[n] = (cb < ca) ? cb : ca;
      if (nw[n] < HALF) all_hi = 1'b0;
    end
    for (int n = 0; n < 64; n++) begin
      mpm[n] = all_hi ? nw[n] - HALF : nw[n];
      de.pm[n*8 +: 8] = 8'(mpm[n]);
    end
    de.dec = d;
    bi = 0;
    for (int n = 1; n < 64; n++) if (mpm[n] < mpm[bi]) bi = n;
    be.st  = 6'(bi);
    be.met = 8'(mpm[bi]);
    dq.push_back(de);
    bq.push_back(be);
  endtask

  // Called at posedge+1; applies inputs, records expectations, returns at
  // the next posedge+1 with the step already registered by the DUT.
  task automatic drive(input logic v, input logic f, input logic [127:0] b0,
                       input logic [127:0] b1);
    in_valid = v;
    in_first = f;
    bm0      = b0;
    bm1      = b1;
    if (v) model_step(f, b0, b1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (dec_valid === 1'b1) begin
      dec_cnt++;
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL dec_unexpected dec_valid=1 with no step pending t=%0t", $time);
      end else begin
        mon_de = dq.pop_front();
        if (dec !== mon_de.dec) begin
          errors++;
          $display("FAIL sb_dec got=%h exp=%h t=%0t", dec, mon_de.dec, $time);
        end
        checks++;
        if (pm_out !== mon_de.pm) begin
          errors++;
          $display("FAIL sb_pm got=%h exp=%h t=%0t", pm_out, mon_de.pm, $time);
        end
      end
    end
    if (best_valid === 1'b1) begin
      best_cnt++;
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL best_unexpected best_valid=1 with nothing pending t=%0t", $time);
      end else begin
        mon_be = bq.pop_front();
        if (best_state !== mon_be.st || best_metric !== mon_be.met) begin
          errors++;
          $display("FAIL sb_best got=%0d/%0d exp=%0d/%0d t=%0t", best_state,
                   best_metric, mon_be.st, mon_be.met, $time);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    bm0      = '0;
    bm1      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pm_out !== init_vec()) begin
      errors++;
      $display("FAIL reset_pm got=%h exp=%h", pm_out, init_vec());
    end
    checks++;
    if (dec_valid !== 1'b0 || best_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b%b exp=00", dec_valid, best_valid);
    end
    checks++;
    if (dec !== 64'd0 || best_state !== 6'd0 || best_metric !== 8'd0) begin
      errors++;
      $display("FAIL reset_data dec=%h bs=%0d bm=%0d exp=0/0/0", dec, best_state, best_metric);
    end
  endtask

  task automatic check_first_step(input string tag);
    checks++;
    if (dec_valid !== 1'b1 || dec !== 64'd0) begin
      errors++;
      $display("FAIL %s_dec got=%b/%h exp=1/0", tag, dec_valid, dec);
    end
    checks++;
    if (pm_out[0 +: 8] !== 8'd0 || pm_out[8 +: 8] !== 8'd2 ||
        pm_out[16 +: 8] !== 8'd64 || pm_out[24 +: 8] !== 8'd66 ||
        pm_out[62*8 +: 8] !== 8'd64 || pm_out[63*8 +: 8] !== 8'd66) begin
      errors++;
      $display("FAIL %s_pm got=%0d,%0d,%0d,%0d,%0d,%0d exp=0,2,64,66,64,66", tag,
               pm_out[0 +: 8], pm_out[8 +: 8], pm_out[16 +: 8], pm_out[24 +: 8],
               pm_out[62*8 +: 8], pm_out[63*8 +: 8]);
    end
    drive(1'b0, 1'b0, B0, B0);
    checks++;
    if (best_valid !== 1'b1 || best_state !== 6'd0 || best_metric !== 8'd0) begin
      errors++;
      $display("FAIL %s_best got=%b/%0d/%0d exp=1/0/0", tag, best_valid, best_state, best_metric);
    end
  endtask

  task automatic test_first_step();
    drive(1'b1, 1'b1, B0, B2);
    check_first_step("first");
    drive(1'b0, 1'b0, B0, B0);
  endtask

  task automatic test_normalize();
    drive(1'b1, 1'b1, B2, B2);
    repeat (62) drive(1'b1, 1'b0, B2, B2);
    checks++;
    if (pm_out !== {64{8'd126}}) begin
      errors++;
      $display("FAIL norm_pm126 got=%h exp=all 7e", pm_out);
    end
    drive(1'b1, 1'b0, B2, B2);
    checks++;
    if (pm_out !== 512'd0) begin
      errors++;
      $display("FAIL norm_pm0 got=%h exp=0", pm_out);
    end
    checks++;
    if (best_metric !== 8'd126) begin
      errors++;
      $display("FAIL norm_best126 got=%0d exp=126", best_metric);
    end
    drive(1'b0, 1'b0, B0, B0);
    checks++;
    if (best_metric !== 8'd0 || best_state !== 6'd0) begin
      errors++;
      $display("FAIL norm_best0 got=%0d/%0d exp=0/0", best_state, best_metric);
    end
    drive(1'b0, 1'b0, B0, B0);
  endtask

  task automatic test_ties();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, (k == 0), B1, B1);
      checks++;
      if (dec !== 64'd0) begin
        errors++;
        $display("FAIL ties_dec step=%0d got=%h exp=0", k, dec);
      end
    end
    drive(1'b0, 1'b0, B0, B0);
    checks++;
    if (best_state !== 6'd0 || best_metric !== 8'd10) begin
      errors++;
      $display("FAIL ties_best got=%0d/%0d exp=0/10", best_state, best_metric);
    end
    drive(1'b0, 1'b0, B0, B0);
  endtask

  task automatic test_gapped();
    int           d0;
    int           b0c;
    logic [511:0] snap;
    d0  = dec_cnt;
    b0c = best_cnt;
    drive(1'b1, 1'b0, rand_bm(), rand_bm());
    snap = pm_out;
    drive(1'b0, 1'b1, rand_bm(), rand_bm());
    checks++;
    if (pm_out !== snap || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap1_hold pm_changed=%b dec_valid=%b exp=0/0", pm_out !== snap, dec_valid);
    end
    drive(1'b0, 1'b0, rand_bm(), rand_bm());
    checks++;
    if (pm_out !== snap || best_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap2_hold pm_changed=%b best_valid=%b exp=0/0", pm_out !== snap, best_valid);
    end
    drive(1'b1, 1'b0, rand_bm(), rand_bm());
    drive(1'b0, 1'b0, B0, B0);
    drive(1'b0, 1'b0, B0, B0);
    checks++;
    if (dec_cnt - d0 != 2 || best_cnt - b0c != 2) begin
      errors++;
      $display("FAIL gap_pulses dec=%0d best=%0d exp=2/2", dec_cnt - d0, best_cnt - b0c);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    int b0c;
    drive(1'b1, 1'b1, rand_bm(), rand_bm());
    drive(1'b1, 1'b0, rand_bm(), rand_bm());
    drive(1'b1, 1'b0, rand_bm(), rand_bm());
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pm_out !== init_vec() || dec !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_data pm=%h dec=%h exp=init/0", pm_out, dec);
    end
    checks++;
    if (dec_valid !== 1'b0 || best_valid !== 1'b0 || best_state !== 6'd0 ||
        best_metric !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_ctrl got=%b/%b/%0d/%0d exp=0/0/0/0", dec_valid, best_valid,
               best_state, best_metric);
    end
    dq.delete();
    bq.delete();
    model_reset();
    d0  = dec_cnt;
    b0c = best_cnt;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, B0, B0);
    checks++;
    if (dec_cnt != d0 || best_cnt != b0c) begin
      errors++;
      $display("FAIL rstmid_pulse dec=%0d best=%0d exp=0/0", dec_cnt - d0, best_cnt - b0c);
    end
    drive(1'b1, 1'b1, B0, B2);
    check_first_step("rstmid");
    drive(1'b0, 1'b0, B0, B0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, rand_bm(), rand_bm());
    for (int k = 0; k < 80; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand_bm(), rand_bm());
    end
    repeat (3) drive(1'b0, 1'b0, B0, B0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    dec_cnt  = 0;
    best_cnt = 0;
    B0 = '0;
    B1 = {64{2'b01}};
    B2 = {64{2'b10}};
    test_reset();
    test_first_step();
    test_normalize();
    test_ties();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (dq.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover dec=%0d best=%0d exp=0/0", dq.size(), bq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_acs_pm_unit_64
